// File: rtl/gpio_display_pkg.sv
// Shared types and constants for the GPIO decimal display.
package gpio_display_pkg;

    localparam int NDIG = 8;   // digits shown on the HEX pins
    localparam int NBCD = 10;  // BCD digits needed for a full 32-bit value

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/gpio_display_hexto7seg.sv
// One BCD code to one active-low seven-segment pattern; codes 10-15 are blank.
module hexto7seg
    import gpio_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Pure lookup; anything that is not a decimal digit lights nothing.
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0: seg = SEG_DIGIT[0];
            4'd1: seg = SEG_DIGIT[1];
            4'd2: seg = SEG_DIGIT[2];
            4'd3: seg = SEG_DIGIT[3];
            4'd4: seg = SEG_DIGIT[4];
            4'd5: seg = SEG_DIGIT[5];
            4'd6: seg = SEG_DIGIT[6];
            4'd7: seg = SEG_DIGIT[7];
            4'd8: seg = SEG_DIGIT[8];
            4'd9: seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/gpio_display.sv
// Watches the CPU gpio_out word, converts each new value to decimal with a
// sequential double-dabble engine, and drives eight active-low HEX digits.
module gpio_display
    import gpio_display_pkg::*;
#(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        ovf,
    output logic        busy
);

    state_t       state_q, state_d;
    logic [31:0]  captured_q, captured_d;
    logic [31:0]  bin_q, bin_d;
    logic [39:0]  bcd_q, bcd_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [31:0]  digits_q, digits_d;
    logic         ovf_q, ovf_d;
    logic         busy_q, busy_d;

    logic [39:0]  bcd_adj;
    logic [71:0]  shifted;
    logic [3:0]   digit_code [NDIG];
    logic [6:0]   seg_raw    [NDIG];
    logic [6:0]   seg_out    [NDIG];

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            captured_q <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state: a new value starts 32 shifts, then one cycle to publish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (value != captured_q) state_d = SHIFT;
            SHIFT:   if (cnt_q == 6'd31)      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NBCD; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                           : bcd_q[i*4 +: 4];
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Datapath updates per state; the display registers change only in DONE.
    always_comb begin
        captured_d = captured_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (value != captured_q) begin
                    captured_d = value;
                    bin_d      = value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                end
            end
            SHIFT: begin
                bcd_d = shifted[71:32];
                bin_d = shifted[31:0];
                cnt_d = cnt_q + 6'd1;
            end
            DONE: begin
                digits_d = bcd_q[31:0];
                ovf_d    = |bcd_q[39:32];
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        assign digit_code[k] = digits_q[k*4 +: 4];
        hexto7seg u_seg (
            .code (digit_code[k]),
            .seg  (seg_raw[k])
        );
    end

    // Leading-zero blanking from the top digit down; hex0 always shows.
    always_comb begin
        logic upper_nz;
        upper_nz = 1'b0;
        for (int k = 0; k < NDIG; k++) seg_out[k] = seg_raw[k];
        for (int k = NDIG - 1; k >= 1; k--) begin
            upper_nz = upper_nz | (digit_code[k] != 4'd0);
            if (BLANK_LEADING && !ovf_q && !upper_nz) seg_out[k] = SEG_BLANK;
        end
    end

    assign hex0 = seg_out[0];
    assign hex1 = seg_out[1];
    assign hex2 = seg_out[2];
    assign hex3 = seg_out[3];
    assign hex4 = seg_out[4];
    assign hex5 = seg_out[5];
    assign hex6 = seg_out[6];
    assign hex7 = seg_out[7];
    assign ovf  = ovf_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_gpio_display.sv
// Directed bench for gpio_display: scoreboard of expected displays per value.
module tb_gpio_display;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        ovf;
  logic        busy;

  logic [56:0] exp_q[$];
  logic [56:0] last_disp;
  logic [56:0] disp;
  int          checks;
  int          errors;

  gpio_display dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .hex0  (hex0),
    .hex1  (hex1),
    .hex2  (hex2),
    .hex3  (hex3),
    .hex4  (hex4),
    .hex5  (hex5),
    .hex6  (hex6),
    .hex7  (hex7),
    .ovf   (ovf),
    .busy  (busy)
  );

  assign disp = {ovf, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  // Expected {ovf, hex7..hex0} for a displayed value, default blanking on.
  function automatic logic [56:0] model(input logic [31:0] v);
    logic [63:0] t;
    logic [3:0]  d[8];
    logic        ov;
    logic        nz;
    logic [6:0]  s;
    logic [56:0] r;
    t  = {32'd0, v};
    ov = (v > 32'd99999999);
    for (int k = 0; k < 8; k++) begin
      d[k] = 4'(t % 64'd10);
      t    = t / 64'd10;
    end
    r     = '0;
    r[56] = ov;
    nz    = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      nz = nz | (d[k] != 4'd0);
      s  = seg_of(d[k]);
      if (k > 0 && !nz && !ov) s = 7'h7f;
      r[k*7 +: 7] = s;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Driver: present a value and let the scoreboard know what it should show.
  task automatic drive_value(input logic [31:0] v);
    value = v;
    exp_q.push_back(model(v));
  endtask

  // Wait out one conversion starting at the next edge, then score the display.
  task automatic run_conv(input string tag);
    int          n;
    logic [56:0] exp_v;
    tick();
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 16) check({tag, "_stable"}, 64'(disp), 64'(last_disp));
      tick();
      n++;
    end
    check({tag, "_busy_len"}, 64'(n), 64'd33);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      exp_v = exp_q.pop_front();
      check({tag, "_disp"}, 64'(disp), 64'(exp_v));
      last_disp = exp_v;
    end
  endtask

  initial begin
    int          n;
    int          busy_seen;
    logic [56:0] exp_v;
    logic [31:0] rv;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    value  = 32'd0;
    repeat (2) tick();

    // reset state
    check("rst_disp", 64'(disp), 64'(model(32'd0)));
    check("rst_ovf",  64'(ovf),  64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    last_disp = model(32'd0);

    // value 0 after reset must not start anything
    busy_seen = 0;
    repeat (40) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
    end
    check("zero_no_busy", 64'(busy_seen), 64'd0);
    check("zero_disp", 64'(disp), 64'(model(32'd0)));

    // main function and digit/overflow boundaries
    drive_value(32'd1234);        run_conv("v1234");
    drive_value(32'd99999999);    run_conv("v99999999");
    drive_value(32'd100000000);   run_conv("v100000000");
    drive_value(32'hFFFFFFFF);    run_conv("vffffffff");
    drive_value(32'd7);           run_conv("v7");
    drive_value(32'd10000000);    run_conv("v10000000");
    for (int i = 0; i < 3; i++) begin
      rv = $urandom_range(32'd1, 32'hFFFFFFFE);
      if (rv == value) rv = rv + 32'd1;
      drive_value(rv);
      run_conv("vrand");
    end

    // value changes mid-conversion: 5, then 77 at E10, 88 at E20
    drive_value(32'd5);
    tick();
    check("chg_busy_start", 64'(busy), 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
      if (n == 10) value = 32'd77;
      if (n == 20) value = 32'd88;
      if (n == 25) check("chg_stable", 64'(disp), 64'(last_disp));
    end
    check("chg_busy_len", 64'(n), 64'd33);
    exp_v = exp_q.pop_front();
    check("chg_disp5", 64'(disp), 64'(exp_v));
    last_disp = exp_v;
    exp_q.push_back(model(32'd88));
    run_conv("chg88");

    // reset in the middle of converting 12345678
    drive_value(32'd12345678);
    tick();
    repeat (14) tick();
    check("midrst_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_disp", 64'(disp), 64'(model(32'd0)));
    tick();
    check("midrst_hold", 64'(disp), 64'(model(32'd0)));
    rst = 1'b0;
    last_disp = model(32'd0);
    run_conv("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
